// File: rtl/fmap_capture_streamer.sv
// fmap_capture_streamer
// Captures the parallel result vectors of a 1x1 expand layer (one vector per
// output pixel) into a pixel-row buffer, pulses ram_feedback_o once the map is
// complete, then replays the map channel-major as a serial stream with an
// enable. Each pixel is followed by one zero pad slot.
// Build option: define FMAP_PARITY_EN to keep one even-parity bit per stored
// word and raise a sticky par_err_o when an emitted word fails its check.
module fmap_capture_streamer #(
  parameter int WIDTH  = 16,
  parameter int DSP_NO = 368,
  parameter int WOUT   = 8,
  parameter int CH_OUT = 368
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             layer_sample_i,
  input  logic             layer_finish_i,
  input  logic [WIDTH-1:0] ofm_i [0:DSP_NO-1],
  output logic             ram_feedback_o,
  output logic             next_en_o,
  output logic [WIDTH-1:0] pix_o,
  input  logic             stall_i,
  output logic             stream_done_o,
  output logic             par_err_o
);

  localparam int DEPTH = WOUT * WOUT;
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int WRW   = $clog2(DEPTH + 1);
  localparam int CW    = $clog2(CH_OUT + 1);
  localparam int ROW_W = DSP_NO * WIDTH;

  localparam logic [AW-1:0]  LAST_RD  = AW'(DEPTH - 1);
  localparam logic [WRW-1:0] LAST_WR  = WRW'(DEPTH - 1);
  localparam logic [WRW-1:0] FULL_WR  = WRW'(DEPTH);
  localparam logic [CW-1:0]  PAD_SLOT = CW'(CH_OUT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CAPTURE,
    S_FEEDBACK,
    S_STREAM,
    S_DONE
  } state_t;

  state_t           state_reg, state_next;
  logic [WRW-1:0]   wr_row_reg, wr_row_next;
  logic [AW-1:0]    rd_row_reg, rd_row_next;
  logic [CW-1:0]    ch_reg, ch_next;
  logic             finish_q_reg;
  logic             next_en_reg;
  logic [WIDTH-1:0] pix_reg;
  logic             done_reg;

  logic             wr_en;
  logic             rd_en;
  logic [AW-1:0]    rd_addr;
  logic             emit;
  logic             pad_slot;
  logic             finish_rise;

  logic [ROW_W-1:0] mem [0:DEPTH-1];
  logic [ROW_W-1:0] wr_data;
  logic [ROW_W-1:0] hold_reg;
  logic [WIDTH-1:0] hold_word [0:DSP_NO-1];
  logic [WIDTH-1:0] cur_word;

  genvar gi;

  // Pack the incoming vector into one buffer row and unpack the holding register.
  generate
    for (gi = 0; gi < DSP_NO; gi++) begin : g_pack
      assign wr_data[gi*WIDTH +: WIDTH] = ofm_i[gi];
      assign hold_word[gi]              = hold_reg[gi*WIDTH +: WIDTH];
    end
  endgenerate

  assign pad_slot    = (ch_reg == PAD_SLOT);
  assign finish_rise = layer_finish_i & ~finish_q_reg;

  // Select the channel currently being emitted from the holding register.
  always_comb begin
    cur_word = '0;
    for (int i = 0; i < CH_OUT; i++) begin
      if (ch_reg == CW'(i)) cur_word = hold_word[i];
    end
  end

  // Row buffer: write on captured samples, registered read into the holding register.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_row_reg[AW-1:0]] <= wr_data;
    if (rd_en) hold_reg <= mem[rd_addr];
  end

  // Next-state, counter and buffer-control decode.
  always_comb begin
    state_next  = state_reg;
    wr_row_next = wr_row_reg;
    rd_row_next = rd_row_reg;
    ch_next     = ch_reg;
    wr_en       = 1'b0;
    rd_en       = 1'b0;
    rd_addr     = '0;
    emit        = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (layer_sample_i) begin
          wr_en       = 1'b1;
          wr_row_next = wr_row_reg + WRW'(1);
          state_next  = (wr_row_reg == LAST_WR) ? S_FEEDBACK : S_CAPTURE;
        end
      end
      S_CAPTURE: begin
        // An early end-of-layer means the map can never complete: abandon it.
        if (finish_rise && (wr_row_reg < FULL_WR)) begin
          state_next = S_DONE;
        end else if (layer_sample_i) begin
          wr_en       = 1'b1;
          wr_row_next = wr_row_reg + WRW'(1);
          if (wr_row_reg == LAST_WR) state_next = S_FEEDBACK;
        end
      end
      S_FEEDBACK: begin
        // Fetch row 0 so the first pixel is ready as soon as streaming starts.
        rd_en      = 1'b1;
        rd_addr    = '0;
        state_next = S_STREAM;
      end
      S_STREAM: begin
        if (!stall_i) begin
          emit = 1'b1;
          if (pad_slot) begin
            ch_next = '0;
            if (rd_row_reg == LAST_RD) begin
              state_next = S_DONE;
            end else begin
              // Prefetch during the pad slot keeps pixels back to back.
              rd_en       = 1'b1;
              rd_addr     = rd_row_reg + AW'(1);
              rd_row_next = rd_row_reg + AW'(1);
            end
          end else begin
            ch_next = ch_reg + CW'(1);
          end
        end
      end
      S_DONE: begin
        state_next = S_DONE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // State, counters and registered stream outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= S_IDLE;
      wr_row_reg   <= '0;
      rd_row_reg   <= '0;
      ch_reg       <= '0;
      finish_q_reg <= 1'b0;
      next_en_reg  <= 1'b0;
      pix_reg      <= '0;
      done_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      wr_row_reg   <= wr_row_next;
      rd_row_reg   <= rd_row_next;
      ch_reg       <= ch_next;
      finish_q_reg <= layer_finish_i;
      // Delayed by one cycle so done never overlaps the final pad enable.
      done_reg     <= (state_reg == S_DONE);
      if (emit) begin
        next_en_reg <= 1'b1;
        pix_reg     <= pad_slot ? '0 : cur_word;
      end else if (state_reg == S_STREAM) begin
        next_en_reg <= 1'b0;
      end else begin
        next_en_reg <= 1'b0;
        pix_reg     <= '0;
      end
    end
  end

  assign ram_feedback_o = (state_reg == S_FEEDBACK);
  assign next_en_o      = next_en_reg;
  assign pix_o          = pix_reg;
  assign stream_done_o  = done_reg;

`ifdef FMAP_PARITY_EN
  logic [DSP_NO-1:0] par_mem [0:DEPTH-1];
  logic [DSP_NO-1:0] wr_par;
  logic [DSP_NO-1:0] par_hold_reg;
  logic              cur_par;
  logic              par_err_reg;

  // Even parity of each incoming word.
  generate
    for (gi = 0; gi < DSP_NO; gi++) begin : g_par
      assign wr_par[gi] = ^ofm_i[gi];
    end
  endgenerate

  // Parity side buffer, addressed exactly like the data rows.
  always_ff @(posedge clk) begin
    if (wr_en) par_mem[wr_row_reg[AW-1:0]] <= wr_par;
    if (rd_en) par_hold_reg <= par_mem[rd_addr];
  end

  // Parity bit belonging to the channel being emitted.
  always_comb begin
    cur_par = 1'b0;
    for (int i = 0; i < CH_OUT; i++) begin
      if (ch_reg == CW'(i)) cur_par = par_hold_reg[i];
    end
  end

  // Sticky error flag; the stream keeps running after a mismatch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      par_err_reg <= 1'b0;
    end else if (emit && !pad_slot && ((^cur_word) != cur_par)) begin
      par_err_reg <= 1'b1;
    end
  end

  assign par_err_o = par_err_reg;
`else
  assign par_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_fmap_capture_streamer.sv
// Self-checking bench for fmap_capture_streamer (WOUT=2, CH_OUT=3, DSP_NO=4).
// Expected stream words are queued when samples are driven and popped by a
// monitor whenever next_en_o is observed high.
module tb_fmap_capture_streamer;
  localparam int WIDTH  = 16;
  localparam int DSP_NO = 4;
  localparam int WOUT   = 2;
  localparam int CH_OUT = 3;
  localparam int DEPTH  = WOUT * WOUT;

  logic             clk = 1'b0;
  logic             rst;
  logic             layer_sample_i;
  logic             layer_finish_i;
  logic [WIDTH-1:0] ofm_i [0:DSP_NO-1];
  logic             ram_feedback_o;
  logic             next_en_o;
  logic [WIDTH-1:0] pix_o;
  logic             stall_i;
  logic             stream_done_o;
  logic             par_err_o;

  int               checks   = 0;
  int               fails    = 0;
  int               en_count = 0;
  int               fb_count = 0;
  bit               mon_en   = 1'b0;
  logic [WIDTH-1:0] sb [$];
  logic [WIDTH-1:0] exp_pix;

  fmap_capture_streamer #(
    .WIDTH(WIDTH), .DSP_NO(DSP_NO), .WOUT(WOUT), .CH_OUT(CH_OUT)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .layer_sample_i(layer_sample_i),
    .layer_finish_i(layer_finish_i),
    .ofm_i         (ofm_i),
    .ram_feedback_o(ram_feedback_o),
    .next_en_o     (next_en_o),
    .pix_o         (pix_o),
    .stall_i       (stall_i),
    .stream_done_o (stream_done_o),
    .par_err_o     (par_err_o)
  );

  always #5 clk = ~clk;

  // Scoreboard monitor: one line per streamed word.
  always @(negedge clk) begin
    if (ram_feedback_o) fb_count++;
    if (mon_en && next_en_o) begin
      en_count++;
      checks++;
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL stream_underflow: got pix %0d with enable, expected no transfer", pix_o);
      end else begin
        exp_pix = sb.pop_front();
        if (pix_o !== exp_pix) begin
          fails++;
          $display("FAIL stream_pix: got %0d expected %0d", pix_o, exp_pix);
        end else begin
          $display("xfer %0d: pix=%0d", en_count, pix_o);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    layer_sample_i = 1'b0;
    layer_finish_i = 1'b0;
    stall_i = 1'b0;
    mon_en = 1'b0;
    sb.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    en_count = 0;
    fb_count = 0;
  endtask

  // Drive one sample (values base+c) for one cycle; optionally queue its stream.
  task automatic send_sample(input logic [WIDTH-1:0] base, input bit push);
    for (int c = 0; c < DSP_NO; c++) ofm_i[c] = base + WIDTH'(c);
    layer_sample_i = 1'b1;
    if (push) begin
      for (int c = 0; c < CH_OUT; c++) sb.push_back(base + WIDTH'(c));
      sb.push_back('0);
    end
    @(negedge clk);
    layer_sample_i = 1'b0;
  endtask

  task automatic wait_drain(input string name, input int budget);
    for (int i = 0; i < budget && sb.size() != 0; i++) @(negedge clk);
    if (sb.size() != 0) begin
      checks++;
      fails++;
      $display("FAIL %s_drain: got %0d words pending, expected 0", name, sb.size());
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    layer_sample_i = 1'b0;
    layer_finish_i = 1'b0;
    stall_i = 1'b0;
    for (int c = 0; c < DSP_NO; c++) ofm_i[c] = '0;
    #3 rst = 1'b1;
    #1;
    checks += 5;
    if (ram_feedback_o !== 1'b0) begin fails++; $display("FAIL reset_fb: got %b expected 0", ram_feedback_o); end
    if (next_en_o !== 1'b0) begin fails++; $display("FAIL reset_en: got %b expected 0", next_en_o); end
    if (pix_o !== '0) begin fails++; $display("FAIL reset_pix: got %0d expected 0", pix_o); end
    if (stream_done_o !== 1'b0) begin fails++; $display("FAIL reset_done: got %b expected 0", stream_done_o); end
    if (par_err_o !== 1'b0) begin fails++; $display("FAIL reset_par: got %b expected 0", par_err_o); end
    $display("reset checked");
    apply_reset();
  endtask

  task automatic test_basic();
    apply_reset();
    mon_en = 1'b1;
    for (int r = 0; r < DEPTH; r++) send_sample(WIDTH'(16 * r), 1'b1);
    checks++;
    if (ram_feedback_o !== 1'b1) begin fails++; $display("FAIL basic_fb_timing: got %b expected 1", ram_feedback_o); end
    @(negedge clk);
    checks++;
    if (next_en_o !== 1'b0) begin fails++; $display("FAIL basic_en_latency1: got %b expected 0", next_en_o); end
    @(negedge clk);
    checks++;
    if (next_en_o !== 1'b1) begin fails++; $display("FAIL basic_en_latency2: got %b expected 1", next_en_o); end
    wait_drain("basic", 60);
    checks += 5;
    if (en_count != 16) begin fails++; $display("FAIL basic_en_count: got %0d expected 16", en_count); end
    if (fb_count != 1) begin fails++; $display("FAIL basic_fb_count: got %0d expected 1", fb_count); end
    if (stream_done_o !== 1'b1) begin fails++; $display("FAIL basic_done: got %b expected 1", stream_done_o); end
    if (next_en_o !== 1'b0) begin fails++; $display("FAIL basic_en_after: got %b expected 0", next_en_o); end
    if (par_err_o !== 1'b0) begin fails++; $display("FAIL basic_par: got %b expected 0", par_err_o); end
    $display("basic capture/stream done");
  endtask

  task automatic test_gaps();
    apply_reset();
    mon_en = 1'b1;
    for (int r = 0; r < DEPTH; r++) begin
      repeat ($urandom_range(100, 126)) @(negedge clk);
      send_sample(WIDTH'($urandom_range(0, 65000)), 1'b1);
    end
    // Extra samples after the map is full must be ignored.
    for (int k = 0; k < 20; k++) send_sample(16'hdead, 1'b0);
    wait_drain("gaps", 60);
    checks += 3;
    if (en_count != 16) begin fails++; $display("FAIL gaps_en_count: got %0d expected 16", en_count); end
    if (fb_count != 1) begin fails++; $display("FAIL gaps_fb_count: got %0d expected 1", fb_count); end
    if (stream_done_o !== 1'b1) begin fails++; $display("FAIL gaps_done: got %b expected 1", stream_done_o); end
    $display("gapped capture done");
  endtask

  task automatic test_stall();
    bit found;
    apply_reset();
    mon_en = 1'b1;
    for (int r = 0; r < DEPTH - 1; r++) send_sample(WIDTH'(16 * r), 1'b1);
    stall_i = 1'b1;
    send_sample(WIDTH'(16 * (DEPTH - 1)), 1'b1);
    // Stall held across the entry into streaming: nothing may start.
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      checks++;
      if (next_en_o !== 1'b0) begin fails++; $display("FAIL stall_start_en: got %b expected 0", next_en_o); end
    end
    stall_i = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      @(negedge clk);
      if (next_en_o && pix_o == 16'd17) found = 1'b1;
    end
    checks++;
    if (!found) begin fails++; $display("FAIL stall_find17: got timeout expected pix 17"); end
    stall_i = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checks += 2;
      if (next_en_o !== 1'b0) begin fails++; $display("FAIL stall_mid_en: got %b expected 0", next_en_o); end
      if (pix_o !== 16'd17) begin fails++; $display("FAIL stall_mid_hold: got %0d expected 17", pix_o); end
    end
    stall_i = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      @(negedge clk);
      if (next_en_o && pix_o == 16'd34) found = 1'b1;
    end
    checks++;
    if (!found) begin fails++; $display("FAIL stall_find34: got timeout expected pix 34"); end
    // Stall landing on the pad slot.
    stall_i = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks += 2;
      if (next_en_o !== 1'b0) begin fails++; $display("FAIL stall_pad_en: got %b expected 0", next_en_o); end
      if (pix_o !== 16'd34) begin fails++; $display("FAIL stall_pad_hold: got %0d expected 34", pix_o); end
    end
    stall_i = 1'b0;
    wait_drain("stall", 60);
    checks += 2;
    if (en_count != 16) begin fails++; $display("FAIL stall_en_count: got %0d expected 16", en_count); end
    if (stream_done_o !== 1'b1) begin fails++; $display("FAIL stall_done: got %b expected 1", stream_done_o); end
    $display("stall sequence done");
  endtask

  task automatic test_reset_stream();
    bit found;
    apply_reset();
    mon_en = 1'b1;
    for (int r = 0; r < DEPTH; r++) send_sample(WIDTH'(16 * r), 1'b1);
    found = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      @(negedge clk);
      if (next_en_o && pix_o == 16'd16) found = 1'b1;
    end
    checks++;
    if (!found) begin fails++; $display("FAIL rststream_find16: got timeout expected pix 16"); end
    mon_en = 1'b0;
    #2 rst = 1'b1;
    #1;
    checks += 4;
    if (next_en_o !== 1'b0) begin fails++; $display("FAIL rststream_en: got %b expected 0", next_en_o); end
    if (pix_o !== '0) begin fails++; $display("FAIL rststream_pix: got %0d expected 0", pix_o); end
    if (stream_done_o !== 1'b0) begin fails++; $display("FAIL rststream_done: got %b expected 0", stream_done_o); end
    if (ram_feedback_o !== 1'b0) begin fails++; $display("FAIL rststream_fb: got %b expected 0", ram_feedback_o); end
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    en_count = 0;
    fb_count = 0;
    mon_en = 1'b1;
    for (int r = 0; r < DEPTH; r++) send_sample(WIDTH'(200 + 16 * r), 1'b1);
    wait_drain("rststream", 60);
    checks += 3;
    if (en_count != 16) begin fails++; $display("FAIL rststream_en_count: got %0d expected 16", en_count); end
    if (fb_count != 1) begin fails++; $display("FAIL rststream_fb_count: got %0d expected 1", fb_count); end
    if (stream_done_o !== 1'b1) begin fails++; $display("FAIL rststream_done2: got %b expected 1", stream_done_o); end
    $display("reset during stream done");
  endtask

  task automatic test_finish_error();
    bit saw_en;
    apply_reset();
    mon_en = 1'b1;
    send_sample(16'd0, 1'b0);
    send_sample(16'd16, 1'b0);
    layer_finish_i = 1'b1;
    saw_en = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (next_en_o) saw_en = 1'b1;
    end
    checks += 3;
    if (fb_count != 0) begin fails++; $display("FAIL finish_fb: got %0d pulses expected 0", fb_count); end
    if (stream_done_o !== 1'b1) begin fails++; $display("FAIL finish_done: got %b expected 1", stream_done_o); end
    if (saw_en) begin fails++; $display("FAIL finish_en: got enable expected none"); end
    layer_finish_i = 1'b0;
    $display("early finish done");
  endtask

`ifdef FMAP_PARITY_EN
  task automatic test_parity();
    bit found;
    apply_reset();
    mon_en = 1'b1;
    for (int r = 0; r < DEPTH; r++) send_sample(WIDTH'(16 * r), 1'b1);
    dut.par_mem[1][2] = ~dut.par_mem[1][2];
    found = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      @(negedge clk);
      if (next_en_o && pix_o == 16'd17) found = 1'b1;
    end
    checks += 2;
    if (!found) begin fails++; $display("FAIL parity_find17: got timeout expected pix 17"); end
    if (par_err_o !== 1'b0) begin fails++; $display("FAIL parity_before: got %b expected 0", par_err_o); end
    @(negedge clk);
    checks++;
    if (par_err_o !== 1'b1) begin fails++; $display("FAIL parity_at18: got %b expected 1", par_err_o); end
    wait_drain("parity", 60);
    checks += 2;
    if (par_err_o !== 1'b1) begin fails++; $display("FAIL parity_sticky: got %b expected 1", par_err_o); end
    if (en_count != 16) begin fails++; $display("FAIL parity_en_count: got %0d expected 16", en_count); end
    $display("parity error injection done");
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_gaps();
    test_stall();
    test_reset_stream();
    test_finish_error();
`ifdef FMAP_PARITY_EN
    test_parity();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
